// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: tracks a 3-bit upstream counter, flags sequence violations and counts 7->0 wraps.
// Ports: clk, rst (sync, active-high); sample_en/count_in (sample strobe and value); clear_err (leave ERROR);
//        locked (in TRACK), wrap_pulse (one cycle per wrap), wrap_count (saturating wraps), seq_err (sticky),
//        onehot_out (decode of last accepted value, only when COUNT_MON_DECODE_EN is defined).
module count_wrap_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [2:0]        count_in,
    input  logic              clear_err,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              seq_err
`ifdef COUNT_MON_DECODE_EN
    ,
    output logic [7:0]        onehot_out
`endif
);
    typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;
    state_t state;
    logic [2:0] prev;
    logic [2:0] succ;
    assign succ = prev + 3'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= 3'd0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            seq_err    <= 1'b0;
`ifdef COUNT_MON_DECODE_EN
            onehot_out <= 8'h00;
`endif
        end else begin
            wrap_pulse <= 1'b0;
            case (state)
                IDLE: if (sample_en) begin
                    prev   <= count_in;
                    state  <= TRACK;
                    locked <= 1'b1;
`ifdef COUNT_MON_DECODE_EN
                    onehot_out <= 8'd1 << count_in;
`endif
                end
                TRACK: if (sample_en) begin
                    if (count_in == succ) begin
                        prev <= count_in;
`ifdef COUNT_MON_DECODE_EN
                        onehot_out <= 8'd1 << count_in;
`endif
                        if (prev == 3'd7) begin
                            wrap_pulse <= 1'b1;
                            if (wrap_count != '1) wrap_count <= wrap_count + 1'b1;
                        end
                    end else if (count_in != prev) begin
                        seq_err <= 1'b1;
                        state   <= ERROR;
                        locked  <= 1'b0;
                    end
                end
                ERROR: if (clear_err) begin
                    state   <= IDLE;
                    seq_err <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb_count_wrap_monitor: directed table, wrap saturation sequence and randomized model comparison.
module tb_count_wrap_monitor;
    logic clk = 1'b0;
    logic rst, sample_en, clear_err;
    logic [2:0] count_in;
    logic locked_a, pulse_a, err_a, locked_b, pulse_b, err_b;
    logic [7:0] wc_a;
    logic [1:0] wc_b;
`ifdef COUNT_MON_DECODE_EN
    logic [7:0] oh_a, oh_b;
`endif
    int n_vec = 0, n_err = 0;

    count_wrap_monitor #(.WRAP_W(8)) dut_a (
        .clk(clk), .rst(rst), .sample_en(sample_en), .count_in(count_in), .clear_err(clear_err),
        .locked(locked_a), .wrap_pulse(pulse_a), .wrap_count(wc_a), .seq_err(err_a)
`ifdef COUNT_MON_DECODE_EN
        , .onehot_out(oh_a)
`endif
    );
    count_wrap_monitor #(.WRAP_W(2)) dut_b (
        .clk(clk), .rst(rst), .sample_en(sample_en), .count_in(count_in), .clear_err(clear_err),
        .locked(locked_b), .wrap_pulse(pulse_b), .wrap_count(wc_b), .seq_err(err_b)
`ifdef COUNT_MON_DECODE_EN
        , .onehot_out(oh_b)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, s;
        logic [2:0] c;
        logic e, l, p;
        logic [7:0] w;
        logic er;
        logic [7:0] oh;
    } vec_t;
    vec_t tbl[26];

    bit m_track, m_err, m_pulse;
    int m_prev, m_wraps, m_oh;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [2:0] c, input logic e);
        rst = r; sample_en = s; count_in = c; clear_err = e;
        @(posedge clk);
        #1;
    endtask

    // behavioural reference: whether we are tracking, in error, the last accepted value and an unbounded wrap tally
    task automatic model(input logic r, input logic s, input int c, input logic e);
        if (r) begin
            m_track = 0; m_err = 0; m_pulse = 0; m_prev = 0; m_wraps = 0; m_oh = 0;
            return;
        end
        m_pulse = 0;
        if (m_err) begin
            if (e) m_err = 0;
        end else if (!m_track) begin
            if (s) begin m_track = 1; m_prev = c; m_oh = 1 << c; end
        end else if (s) begin
            if (c == (m_prev + 1) % 8) begin
                if (m_prev == 7) begin m_pulse = 1; m_wraps++; end
                m_prev = c; m_oh = 1 << c;
            end else if (c != m_prev) begin
                m_err = 1; m_track = 0;
            end
        end
    endtask

    task automatic check_all(input string tag, input logic l, input logic p, input int w,
                             input logic er, input logic [7:0] oh);
        chk({tag, ".locked"}, locked_a, l);
        chk({tag, ".wrap_pulse"}, pulse_a, p);
        chk({tag, ".wrap_count8"}, wc_a, (w > 255) ? 255 : w);
        chk({tag, ".seq_err"}, err_a, er);
        chk({tag, ".locked_w2"}, locked_b, l);
        chk({tag, ".wrap_pulse_w2"}, pulse_b, p);
        chk({tag, ".wrap_count2"}, wc_b, (w > 3) ? 3 : w);
        chk({tag, ".seq_err_w2"}, err_b, er);
`ifdef COUNT_MON_DECODE_EN
        chk({tag, ".onehot"}, oh_a, oh);
        chk({tag, ".onehot_w2"}, oh_b, oh);
`else
        if (oh === 8'hxx) n_err += 0;
`endif
    endtask

    initial begin
        int pulses;
        rst = 1; sample_en = 0; count_in = 0; clear_err = 0;
        //           r  s  c  e  l  p  w  er  oh
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 1, 3, 0, 1, 0, 0, 0, 8'h08};
        tbl[2]  = '{0, 1, 4, 0, 1, 0, 0, 0, 8'h10};
        tbl[3]  = '{0, 1, 5, 0, 1, 0, 0, 0, 8'h20};
        tbl[4]  = '{0, 1, 6, 0, 1, 0, 0, 0, 8'h40};
        tbl[5]  = '{0, 1, 7, 0, 1, 0, 0, 0, 8'h80};
        tbl[6]  = '{0, 1, 0, 0, 1, 1, 1, 0, 8'h01};
        tbl[7]  = '{0, 1, 1, 0, 1, 0, 1, 0, 8'h02};
        tbl[8]  = '{0, 1, 1, 0, 1, 0, 1, 0, 8'h02};
        tbl[9]  = '{0, 1, 2, 0, 1, 0, 1, 0, 8'h04};
        tbl[10] = '{0, 1, 2, 0, 1, 0, 1, 0, 8'h04};
        tbl[11] = '{0, 1, 2, 0, 1, 0, 1, 0, 8'h04};
        tbl[12] = '{0, 1, 3, 0, 1, 0, 1, 0, 8'h08};
        tbl[13] = '{0, 0, 7, 0, 1, 0, 1, 0, 8'h08};
        tbl[14] = '{0, 1, 4, 0, 1, 0, 1, 0, 8'h10};
        tbl[15] = '{0, 1, 6, 0, 0, 0, 1, 1, 8'h10};
        tbl[16] = '{0, 1, 7, 0, 0, 0, 1, 1, 8'h10};
        tbl[17] = '{0, 1, 0, 0, 0, 0, 1, 1, 8'h10};
        tbl[18] = '{0, 1, 5, 1, 0, 0, 1, 0, 8'h10};
        tbl[19] = '{0, 1, 5, 0, 1, 0, 1, 0, 8'h20};
        tbl[20] = '{0, 1, 6, 0, 1, 0, 1, 0, 8'h40};
        tbl[21] = '{0, 1, 7, 0, 1, 0, 1, 0, 8'h80};
        tbl[22] = '{0, 1, 0, 0, 1, 1, 2, 0, 8'h01};
        tbl[23] = '{0, 0, 0, 1, 1, 0, 2, 0, 8'h01};
        tbl[24] = '{1, 1, 1, 0, 0, 0, 0, 0, 8'h00};
        tbl[25] = '{0, 0, 0, 1, 0, 0, 0, 0, 8'h00};
        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].e);
            check_all($sformatf("vec%0d", i), tbl[i].l, tbl[i].p, int'(tbl[i].w), tbl[i].er, tbl[i].oh);
        end

        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        pulses = 0;
        for (int k = 0; k < 5; k++)
            for (int v = 1; v <= 8; v++) begin
                cyc(0, 1, 3'(v % 8), 0);
                if (pulse_b) pulses++;
            end
        cyc(0, 0, 0, 0);
        chk("sat.pulses", pulses, 5);
        chk("sat.wrap_count2", wc_b, 3);
        chk("sat.wrap_count8", wc_a, 5);
        chk("sat.pulse_low", pulse_b, 0);

        cyc(1, 0, 0, 0);
        model(1, 0, 0, 0);
        check_all("rnd_reset", m_track, m_pulse, m_wraps, m_err, 8'(m_oh));
        for (int i = 0; i < 800; i++) begin
            logic r, s, e;
            int c, k;
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 3) != 0);
            e = ($urandom_range(0, 4) == 0);
            k = $urandom_range(0, 19);
            c = (k < 14) ? (m_prev + 1) % 8 : (k < 17) ? m_prev : $urandom_range(0, 7);
            cyc(r, s, 3'(c), e);
            model(r, s, c, e);
            check_all($sformatf("rnd%0d", i), m_track, m_pulse, m_wraps, m_err, 8'(m_oh));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
